// File: rtl/i2c_efb_wb_arbiter.sv
// i2c_efb_wb_arbiter: round-robin two-master Wishbone arbiter sharing the EFB port.
// Optional stalled-strobe watchdog is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_efb_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter bit FIRST_PRIORITY = 1'b0
) (
    input  logic       sys_clk,
    input  logic       rstn,
    input  logic       m1_cyc,
    input  logic       m1_stb,
    input  logic       m1_we,
    input  logic [7:0] m1_adr,
    input  logic [7:0] m1_dat_w,
    output logic [7:0] m1_dat_r,
    output logic       m1_ack,
    output logic       m1_gnt,
    output logic       m1_err,
    input  logic       m2_cyc,
    input  logic       m2_stb,
    input  logic       m2_we,
    input  logic [7:0] m2_adr,
    input  logic [7:0] m2_dat_w,
    output logic [7:0] m2_dat_r,
    output logic       m2_ack,
    output logic       m2_gnt,
    output logic       m2_err,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    output logic       wb_we_o,
    output logic [7:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        GNT1,
        GNT2,
        RELEASE
    } state_t;

    state_t state;
    logic   last_owner;
    logic   g1;
    logic   g2;
    logic   req1;
    logic   req2;
    logic   tmo1;
    logic   tmo2;
    logic   blk1;
    logic   blk2;

    assign g1   = (state == GNT1);
    assign g2   = (state == GNT2);
    assign req1 = m1_cyc & ~blk1;
    assign req2 = m2_cyc & ~blk2;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt;
    logic        stall1;
    logic        stall2;

    assign stall1 = g1 & m1_cyc & m1_stb & ~wb_ack_i;
    assign stall2 = g2 & m2_cyc & m2_stb & ~wb_ack_i;
    assign tmo1   = stall1 & (cnt == TMO_LAST);
    assign tmo2   = stall2 & (cnt == TMO_LAST);

    // Stall counter and per-master lockout after a forced release
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            cnt  <= '0;
            blk1 <= 1'b0;
            blk2 <= 1'b0;
        end else begin
            if ((stall1 & ~tmo1) | (stall2 & ~tmo2)) begin
                cnt <= cnt + 16'd1;
            end else begin
                cnt <= '0;
            end
            if (tmo1) begin
                blk1 <= 1'b1;
            end else if (!m1_cyc) begin
                blk1 <= 1'b0;
            end
            if (tmo2) begin
                blk2 <= 1'b1;
            end else if (!m2_cyc) begin
                blk2 <= 1'b0;
            end
        end
    end
`else
    // Watchdog compiled out: the budget parameter has no consumer
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES;
    assign tmo1 = 1'b0;
    assign tmo2 = 1'b0;
    assign blk1 = 1'b0;
    assign blk2 = 1'b0;
`endif

    // Ownership FSM: whole-cycle lock, one idle clock between owners
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            last_owner <= ~FIRST_PRIORITY;
        end else begin
            unique case (state)
                IDLE, RELEASE: begin
                    if (req1 & req2) begin
                        state <= last_owner ? GNT1 : GNT2;
                    end else if (req1) begin
                        state <= GNT1;
                    end else if (req2) begin
                        state <= GNT2;
                    end else begin
                        state <= IDLE;
                    end
                end
                GNT1: begin
                    if (!m1_cyc || tmo1) begin
                        state      <= RELEASE;
                        last_owner <= 1'b0;
                    end
                end
                GNT2: begin
                    if (!m2_cyc || tmo2) begin
                        state      <= RELEASE;
                        last_owner <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Route the owner onto the EFB and the EFB response back to the owner only
    always_comb begin
        wb_cyc_o = 1'b0;
        wb_stb_o = 1'b0;
        wb_we_o  = 1'b0;
        wb_adr_o = 8'h00;
        wb_dat_o = 8'h00;
        m1_dat_r = 8'h00;
        m2_dat_r = 8'h00;
        m1_ack   = 1'b0;
        m2_ack   = 1'b0;
        if (g1) begin
            wb_cyc_o = m1_cyc;
            wb_stb_o = m1_stb;
            wb_we_o  = m1_we;
            wb_adr_o = m1_adr;
            wb_dat_o = m1_dat_w;
            m1_dat_r = wb_dat_i;
            m1_ack   = wb_ack_i & m1_stb;
        end else if (g2) begin
            wb_cyc_o = m2_cyc;
            wb_stb_o = m2_stb;
            wb_we_o  = m2_we;
            wb_adr_o = m2_adr;
            wb_dat_o = m2_dat_w;
            m2_dat_r = wb_dat_i;
            m2_ack   = wb_ack_i & m2_stb;
        end
    end

    assign m1_gnt = g1;
    assign m2_gnt = g2;
    assign m1_err = tmo1;
    assign m2_err = tmo2;

endmodule

// File: tb/tb_i2c_efb_wb_arbiter.sv
// tb_i2c_efb_wb_arbiter: vector table, directed corner cases and a randomized
// run against an ownership-level reference model.
module tb_i2c_efb_wb_arbiter;

    localparam int TMO = 8;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic       sys_clk = 1'b0;
    logic       rstn = 1'b0;
    logic       m1_cyc, m1_stb, m1_we;
    logic [7:0] m1_adr, m1_dat_w, m1_dat_r;
    logic       m1_ack, m1_gnt, m1_err;
    logic       m2_cyc, m2_stb, m2_we;
    logic [7:0] m2_adr, m2_dat_w, m2_dat_r;
    logic       m2_ack, m2_gnt, m2_err;
    logic       wb_cyc_o, wb_stb_o, wb_we_o;
    logic [7:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic       wb_ack_i;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    i2c_efb_wb_arbiter #(
        .TIMEOUT_CYCLES(TMO),
        .FIRST_PRIORITY(1'b0)
    ) dut (
        .sys_clk(sys_clk), .rstn(rstn),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we),
        .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r),
        .m1_ack(m1_ack), .m1_gnt(m1_gnt), .m1_err(m1_err),
        .m2_cyc(m2_cyc), .m2_stb(m2_stb), .m2_we(m2_we),
        .m2_adr(m2_adr), .m2_dat_w(m2_dat_w), .m2_dat_r(m2_dat_r),
        .m2_ack(m2_ack), .m2_gnt(m2_gnt), .m2_err(m2_err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    typedef struct {
        logic       c1, s1, c2, s2, ack;
        logic [7:0] din;
        logic       g1, g2, wcyc, wstb;
        logic [7:0] adr;
        logic       a1, a2;
        logic [7:0] r1, r2;
    } vec_t;

    vec_t tv[9];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_dat_w = 0;
        m2_cyc = 0; m2_stb = 0; m2_we = 0; m2_adr = 0; m2_dat_w = 0;
        wb_ack_i = 0; wb_dat_i = 0;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        rstn = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 rstn = 1'b1;
    endtask

    // Reference model: who owns the EFB, who owned it last, stall length
    int m_own, m_last, m_stall;
    bit m_blk1, m_blk2;

    task automatic model_init();
        m_own = 0; m_last = 2; m_stall = 0; m_blk1 = 0; m_blk2 = 0;
    endtask

    task automatic model_check_and_step();
        bit o1, o2, ocyc, ostb, tmo;
        o1 = (m_own == 1);
        o2 = (m_own == 2);
        ocyc = o1 ? m1_cyc : (o2 ? m2_cyc : 1'b0);
        ostb = o1 ? m1_stb : (o2 ? m2_stb : 1'b0);
        tmo = TMO_ON && (m_own != 0) && ocyc && ostb && !wb_ack_i
              && (m_stall == TMO - 1);
        chk("rnd_gnt1", m1_gnt, o1);
        chk("rnd_gnt2", m2_gnt, o2);
        chk("rnd_cyc", wb_cyc_o, ocyc);
        chk("rnd_stb", wb_stb_o, ostb);
        chk("rnd_we", wb_we_o, o1 ? m1_we : (o2 ? m2_we : 1'b0));
        chk("rnd_adr", wb_adr_o, o1 ? m1_adr : (o2 ? m2_adr : 8'h00));
        chk("rnd_dat", wb_dat_o, o1 ? m1_dat_w : (o2 ? m2_dat_w : 8'h00));
        chk("rnd_ack1", m1_ack, o1 && wb_ack_i && m1_stb);
        chk("rnd_ack2", m2_ack, o2 && wb_ack_i && m2_stb);
        chk("rnd_dr1", m1_dat_r, o1 ? wb_dat_i : 8'h00);
        chk("rnd_dr2", m2_dat_r, o2 ? wb_dat_i : 8'h00);
        chk("rnd_err1", m1_err, tmo && o1);
        chk("rnd_err2", m2_err, tmo && o2);
        if (m_own != 0) begin
            if (!ocyc || tmo) begin
                if (tmo && o1) m_blk1 = 1;
                if (tmo && o2) m_blk2 = 1;
                m_last = m_own;
                m_own = 0;
                m_stall = 0;
            end else begin
                m_stall = (ostb && !wb_ack_i) ? m_stall + 1 : 0;
            end
        end else begin
            bit r1, r2;
            r1 = m1_cyc && !m_blk1;
            r2 = m2_cyc && !m_blk2;
            if (r1 && r2) m_own = (m_last == 1) ? 2 : 1;
            else if (r1) m_own = 1;
            else if (r2) m_own = 2;
            m_stall = 0;
        end
        if (!m1_cyc) m_blk1 = 0;
        if (!m2_cyc) m_blk2 = 0;
    endtask

    initial begin
        int acks1, acks2;
        idle_in();

        // Reset with both masters requesting
        m1_cyc = 1; m2_cyc = 1; m1_adr = 8'h3C; m2_adr = 8'hC3;
        wb_ack_i = 1; wb_dat_i = 8'hFF;
        #4;
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_gnt1", m1_gnt, 0);
        chk("rst_gnt2", m2_gnt, 0);
        chk("rst_ack1", m1_ack, 0);
        chk("rst_dr2", m2_dat_r, 0);
        chk("rst_adr", wb_adr_o, 0);
        tick();
        rstn = 1;
        wb_ack_i = 0;
        #4;
        chk("rst_idle_gnt1", m1_gnt, 0);
        tick();
        #4;
        chk("rst_first_gnt1", m1_gnt, 1);
        chk("rst_first_gnt2", m2_gnt, 0);
        chk("rst_first_adr", wb_adr_o, 8'h3C);

        // Vector table: grant, routing, drop, release gap, contention
        tv[0] = '{1,0,1,0,0,8'h00, 0,0,0,0,8'h00,0,0,8'h00,8'h00};
        tv[1] = '{1,0,1,0,0,8'h00, 1,0,1,0,8'h11,0,0,8'h00,8'h00};
        tv[2] = '{1,1,1,1,1,8'h5A, 1,0,1,1,8'h11,1,0,8'h5A,8'h00};
        tv[3] = '{0,0,1,1,1,8'h33, 1,0,0,0,8'h11,0,0,8'h33,8'h00};
        tv[4] = '{1,0,1,0,1,8'h77, 0,0,0,0,8'h00,0,0,8'h00,8'h00};
        tv[5] = '{1,0,1,1,1,8'h44, 0,1,1,1,8'h22,0,1,8'h00,8'h44};
        tv[6] = '{1,0,0,0,0,8'h00, 0,1,0,0,8'h22,0,0,8'h00,8'h00};
        tv[7] = '{1,0,0,0,1,8'h99, 0,0,0,0,8'h00,0,0,8'h00,8'h00};
        tv[8] = '{1,1,0,0,0,8'h00, 1,0,1,1,8'h11,0,0,8'h00,8'h00};
        do_reset();
        m1_adr = 8'h11; m2_adr = 8'h22;
        for (int i = 0; i < 9; i++) begin
            m1_cyc = tv[i].c1; m1_stb = tv[i].s1;
            m2_cyc = tv[i].c2; m2_stb = tv[i].s2;
            wb_ack_i = tv[i].ack; wb_dat_i = tv[i].din;
            #4;
            chk($sformatf("tv%0d_gnt1", i), m1_gnt, tv[i].g1);
            chk($sformatf("tv%0d_gnt2", i), m2_gnt, tv[i].g2);
            chk($sformatf("tv%0d_cyc", i), wb_cyc_o, tv[i].wcyc);
            chk($sformatf("tv%0d_stb", i), wb_stb_o, tv[i].wstb);
            chk($sformatf("tv%0d_adr", i), wb_adr_o, tv[i].adr);
            chk($sformatf("tv%0d_ack1", i), m1_ack, tv[i].a1);
            chk($sformatf("tv%0d_ack2", i), m2_ack, tv[i].a2);
            chk($sformatf("tv%0d_dr1", i), m1_dat_r, tv[i].r1);
            chk($sformatf("tv%0d_dr2", i), m2_dat_r, tv[i].r2);
            tick();
        end

        // Single master write from m2, ack on the third granted clock
        do_reset();
        m2_cyc = 1; m2_stb = 1; m2_we = 1;
        m2_adr = 8'h4A; m2_dat_w = 8'h80;
        tick();
        acks1 = 0; acks2 = 0;
        for (int k = 1; k <= 5; k++) begin
            m2_stb = (k <= 3);
            wb_ack_i = (k == 3 || k == 4);
            #4;
            if (k <= 3) begin
                chk("wr_we", wb_we_o, 1);
                chk("wr_dat", wb_dat_o, 8'h80);
                chk("wr_adr", wb_adr_o, 8'h4A);
            end
            acks1 += int'(m1_ack);
            acks2 += int'(m2_ack);
            tick();
        end
        chk("wr_m2_ack_count", acks2, 1);
        chk("wr_m1_ack_count", acks1, 0);

        // Lock: m1 keeps ownership over 5 beats while m2 waits
        do_reset();
        m1_cyc = 1; m2_cyc = 1; m2_stb = 1;
        tick();
        for (int b = 0; b < 5; b++) begin
            for (int p = 0; p < 3; p++) begin
                m1_stb = (p < 2);
                wb_ack_i = (p == 1);
                wb_dat_i = (p == 1) ? 8'h5A : 8'h00;
                #4;
                chk("lock_gnt1", m1_gnt, 1);
                chk("lock_gnt2", m2_gnt, 0);
                chk("lock_ack2", m2_ack, 0);
                chk("lock_dr2", m2_dat_r, 0);
                if (p == 1) begin
                    chk("lock_ack1", m1_ack, 1);
                    chk("lock_dr1", m1_dat_r, 8'h5A);
                end
                tick();
            end
        end

        // Asynchronous reset between stb and ack
        do_reset();
        m1_cyc = 1; m1_stb = 1;
        tick();
        #4;
        chk("ar_cyc_before", wb_cyc_o, 1);
        #2 rstn = 0;
        #1;
        chk("ar_cyc_async", wb_cyc_o, 0);
        chk("ar_gnt_async", m1_gnt, 0);
        @(posedge sys_clk);
        #1 rstn = 1;
        m1_cyc = 0; m1_stb = 0; wb_ack_i = 1; wb_dat_i = 8'hA5;
        for (int k = 0; k < 2; k++) begin
            #4;
            chk("ar_no_ack", m1_ack, 0);
            chk("ar_no_gnt", m1_gnt, 0);
            chk("ar_no_dr", m1_dat_r, 0);
            tick();
        end

`ifdef I2C_ARB_TIMEOUT_EN
        // Watchdog: m1 stalls, error on the 8th stalled clock, m2 next
        do_reset();
        m1_cyc = 1; m1_stb = 1; m2_cyc = 1;
        for (int k = 0; k <= 10; k++) begin
            #4;
            chk("to_err1", m1_err, k == 8);
            chk("to_gnt1", m1_gnt, k >= 1 && k <= 8);
            chk("to_gnt2", m2_gnt, k == 10);
            tick();
        end
        m2_cyc = 0;
        for (int k = 11; k <= 13; k++) begin
            #4;
            chk("to_blocked_gnt1", m1_gnt, 0);
            tick();
        end
        m1_cyc = 0; m1_stb = 0;
        tick();
        m1_cyc = 1;
        #4;
        chk("to_rereq_idle", m1_gnt, 0);
        tick();
        #4;
        chk("to_rereq_gnt1", m1_gnt, 1);
        tick();
`endif

        // Randomized run against the reference model
        do_reset();
        model_init();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(5) == 0) m1_cyc = ~m1_cyc;
            if ($urandom_range(5) == 0) m2_cyc = ~m2_cyc;
            m1_stb = 1'($urandom_range(1));
            m2_stb = 1'($urandom_range(1));
            m1_we = 1'($urandom_range(1));
            m2_we = 1'($urandom_range(1));
            m1_adr = 8'($urandom);
            m2_adr = 8'($urandom);
            m1_dat_w = 8'($urandom);
            m2_dat_w = 8'($urandom);
            wb_dat_i = 8'($urandom);
            wb_ack_i = ($urandom_range(3) == 0);
            #4;
            model_check_and_step();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_efb_wb_arbiter.md
Name: i2c_efb_wb_arbiter

Overview:
Two-master Wishbone arbiter that shares the single EFB Wishbone slave port between the EFB #1 and EFB #2 I2C driver state machines. Each driver sees a private Wishbone master port. The arbiter grants exclusive EFB ownership for a whole bus cycle (cyc high) using round-robin priority. It inserts a one-clock idle gap between owners and routes read data and ack only to the current owner. It sits between the per-bus I2C drivers and the EFB instance inside the I2C top level.

Parameters:
TIMEOUT_CYCLES, 1024, stb-without-ack clocks before forced release (used only when the optional feature is enabled); legal range 2..65535
FIRST_PRIORITY, 0, master that wins a simultaneous request after reset (0 = m1, 1 = m2)

Ports:
sys_clk  in  1  master clock, rising edge
rstn  in  1  asynchronous active-low reset, 0 = reset
m1_cyc  in  1  master 1 bus cycle request/lock
m1_stb  in  1  master 1 strobe
m1_we  in  1  master 1 write enable
m1_adr  in  8  master 1 EFB register address
m1_dat_w  in  8  master 1 write data
m1_dat_r  out  8  master 1 read data
m1_ack  out  1  master 1 ack
m1_gnt  out  1  master 1 owns the EFB
m1_err  out  1  master 1 timeout error pulse
m2_cyc, m2_stb, m2_we, m2_adr, m2_dat_w, m2_dat_r, m2_ack, m2_gnt, m2_err  same as m1_* for master 2
wb_cyc_o  out  1  EFB cyc
wb_stb_o  out  1  EFB stb
wb_we_o  out  1  EFB we
wb_adr_o  out  8  EFB address
wb_dat_o  out  8  EFB write data
wb_dat_i  in  8  EFB read data
wb_ack_i  in  1  EFB ack

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is asynchronous and active-low on rstn.
- Reset values: state IDLE; last_owner = ~FIRST_PRIORITY; all outputs 0; timeout counter 0.
- States:
  - IDLE:
    - no cyc, stay.
    - exactly one cyc, go to GNT1/GNT2 next clock.
    - both cyc, grant the master that is not last_owner.
  - GNT1:
    - m1_gnt=1. wb_* = m1_* (cyc, stb, we, adr, dat) combinationally from registered state.
    - m1_ack = wb_ack_i & m1_stb. m1_dat_r = wb_dat_i.
    - When m1_cyc falls: go to RELEASE, set last_owner=m1.
  - GNT2: symmetric to GNT1.
  - RELEASE:
    - one clock; all wb_* = 0, no grant.
    - Then evaluate exactly as IDLE (RELEASE→GNTx direct; RELEASE→IDLE only if no request).
- Grant latency: cyc asserted at edge N gives gnt at N+1; the first EFB stb is visible in cycle N+1.
- Masters must hold stb until their own ack.
- Non-owner isolation:
  - Non-owner: ack=0, dat_r=0, gnt=0, regardless of wb_ack_i/wb_dat_i.
  - Non-owner stb is ignored and never forwarded.
- wb_ack_i is never forwarded while in IDLE or RELEASE.
- Ownership persists across multiple stb/ack beats while the owner's cyc stays high (whole I2C transaction locked).
- Other master's cyc during ownership: waits, no effect on the current owner; it is served at the next RELEASE.
- Owner drops cyc in the same clock as wb_ack_i:
  - The ack is still delivered that cycle.
  - Release follows.
- rstn low mid-transfer: immediate return to reset values. wb_cyc_o drops asynchronously.
- Without the optional feature: m1_err = m2_err = 0 constantly.

Optional Feature:
I2C_ARB_TIMEOUT_EN:
- Defined:
  - A 16-bit counter increments each clock in GNTx while the owner's stb=1 and wb_ack_i=0.
  - It clears on ack, on state change, or when stb=0.
  - When count reaches TIMEOUT_CYCLES-1:
    - pulse mx_err for one clock;
    - force RELEASE; set last_owner = that master.
    - The master is ignored until it drops cyc, then may re-request.
- Not defined: counter absent, no forced release, err outputs tied 0.

Test Plan:
- Reset: rstn=0 with both cyc=1 → all outputs 0. Release rstn, FIRST_PRIORITY=0 → m1_gnt=1 one clock later, wb_adr_o=m1_adr.
- Single master: m2 writes adr=0x4A, dat=0x80 with ack after 3 clocks → wb_we_o=1, wb_dat_o=0x80, m2_ack exactly 1 clock, m1_ack stays 0.
- Contention: both cyc in the same clock after m1 last owned → m2 granted. After m2 drops cyc → 1 RELEASE clock (wb_cyc_o=0), then m1 granted.
- Lock: m1 holds cyc over 5 stb/ack beats while m2_cyc=1 → no grant switch. Read data 0x5A reaches only m1_dat_r.
- Async reset mid-transfer (rstn low between stb and ack) → wb_cyc_o=0 same cycle, state IDLE, no stray ack after release.
- Timeout (I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): m1 stb with no ack → m1_err pulses on the 8th stalled clock, RELEASE, m2 granted next.
